// File: rtl/matrix_inv2x2.sv
// 2x2 signed 16.16 matrix inverse: adjugate scaled by a bit-serial restoring reciprocal of det.
// start/busy/done handshake with a singular flag; state is exposed on state_dbg.
module matrix_inv2x2 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a11,
  input  logic [31:0] a12,
  input  logic [31:0] a21,
  input  logic [31:0] a22,
  output logic [31:0] c11,
  output logic [31:0] c12,
  output logic [31:0] c21,
  output logic [31:0] c22,
  output logic        busy,
  output logic        done,
  output logic        singular,
  output logic [1:0]  state_dbg
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DET   = 2'd1;
  localparam logic [1:0] DIV   = 2'd2;
  localparam logic [1:0] SCALE = 2'd3;

  logic [1:0]  state;
  logic [31:0] la11, la12, la21, la22;
  logic [49:0] det_abs;
  logic        det_neg;
  logic [49:0] rem;
  logic [32:0] quo;
  logic [5:0]  bit_idx;

  function automatic logic [65:0] sx66(input logic [31:0] v);
    return {{34{v[31]}}, v};
  endfunction

  function automatic logic [63:0] sx64(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Products are formed on sign-extended operands; the low bits are exact modulo 2^N.
  logic [65:0] prod_ad, prod_bc, det_full;
  logic [49:0] det_c, det_abs_c;
  logic        det_neg_c;

  always_comb begin
    prod_ad   = sx66(la11) * sx66(la22);
    prod_bc   = sx66(la12) * sx66(la21);
    det_full  = prod_ad - prod_bc;
    det_c     = det_full[65:16];
    det_neg_c = det_c[49];
    det_abs_c = det_neg_c ? (50'd0 - det_c) : det_c;
  end

  // Dividend is 2^32: only the first (MSB) iteration shifts in a one.
  logic [50:0] rem_sh, rem_diff, div_ext;
  logic        q_bit;
  logic [49:0] rem_next;

  always_comb begin
    rem_sh   = {rem, (bit_idx == 6'd32)};
    div_ext  = {1'b0, det_abs};
    rem_diff = rem_sh - div_ext;
    q_bit    = (rem_sh >= div_ext);
    rem_next = q_bit ? rem_diff[49:0] : rem_sh[49:0];
  end

  logic [31:0] recip_mag, recip, neg12, neg21;
  logic [63:0] p11, p12, p21, p22;

  always_comb begin
    recip_mag = (quo[32] || quo[31]) ? 32'h7FFF_FFFF : quo[31:0];
    recip     = det_neg ? (32'd0 - recip_mag) : recip_mag;
    neg12     = 32'd0 - la12;
    neg21     = 32'd0 - la21;
    p11       = sx64(la22)  * sx64(recip);
    p12       = sx64(neg12) * sx64(recip);
    p21       = sx64(neg21) * sx64(recip);
    p22       = sx64(la11)  * sx64(recip);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      singular <= 1'b0;
      c11      <= '0;
      c12      <= '0;
      c21      <= '0;
      c22      <= '0;
      la11     <= '0;
      la12     <= '0;
      la21     <= '0;
      la22     <= '0;
      det_abs  <= '0;
      det_neg  <= 1'b0;
      rem      <= '0;
      quo      <= '0;
      bit_idx  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            la11  <= a11;
            la12  <= a12;
            la21  <= a21;
            la22  <= a22;
            busy  <= 1'b1;
            state <= DET;
          end
        end
        DET: begin
          det_abs <= det_abs_c;
          det_neg <= det_neg_c;
          rem     <= '0;
          quo     <= '0;
          bit_idx <= 6'd32;
          state   <= DIV;
        end
        DIV: begin
          if (bit_idx == 6'd32 && det_abs == 50'd0) begin
            c11      <= '0;
            c12      <= '0;
            c21      <= '0;
            c22      <= '0;
            singular <= 1'b1;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            rem     <= rem_next;
            quo     <= {quo[31:0], q_bit};
            bit_idx <= bit_idx - 6'd1;
            if (bit_idx == 6'd0) state <= SCALE;
          end
        end
        SCALE: begin
          c11      <= p11[47:16];
          c12      <= p12[47:16];
          c21      <= p21[47:16];
          c22      <= p22[47:16];
          singular <= 1'b0;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: doc/matrix_inv2x2.md
# matrix_inv2x2

Computes the inverse of a 2x2 signed 16.16 fixed-point matrix, C = A⁻¹. It uses the adjugate/determinant method with a bit-serial restoring reciprocal divider. It mirrors the matrix multiplier in the same datapath: the multiplier composes a transform and this block undoes one. Handshake is start/busy/done, and the block flags singular inputs.

## Interface
- Parameters: none (fixed 16.16 format, 32-bit elements).
- clk  input  1  single clock, rising edge.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  request inverse of a11..a22; sampled only in IDLE.
- a11, a12, a21, a22  input  32 each  matrix A, signed 16.16; sampled on the start-accept edge only.
- c11, c12, c21, c22  output  32 each  inverse, signed 16.16, registered; hold until next completion.
- busy  output  1  high from start-accept edge until the done edge.
- done  output  1  one-cycle completion pulse.
- singular  output  1  registered with done; 1 when det truncates to 0; holds until next completion.

## Operation
- States:
  - IDLE: if start, latch A, busy←1, go to DET.
  - DET: det_full = a11·a22 − a12·a21 (66-bit signed). det = det_full >>> 16 (arithmetic, floor), kept 50 bits. Register det, sign and |det|. Go to DIV.
  - DIV, first cycle, if det == 0: set c* ← 0, singular ← 1, done ← 1, busy ← 0, go to IDLE.
  - DIV, otherwise: restoring division q = 2³²/|det|, 33 iterations, one quotient bit per cycle MSB-first, 50-bit remainder. Go to SCALE after the 33rd iteration.
  - SCALE: apply the adjugate scaling below, then set singular ← 0, done ← 1, busy ← 0, go to IDLE.
- Reciprocal:
  - Saturate: r = min(q, 0x7FFFFFFF).
  - Sign: recip = det negative ? −r : r (signed 32-bit).
  - |det| > 2³² gives q = 0 and outputs 0, with no flag.
- Adjugate scaling: each result is a 32×32 signed product to 64 bits, then >>> 16, keeping bits [31:0] (wrap, no saturation).
  - c11 = a22·recip
  - c12 = (−a12)·recip
  - c21 = (−a21)·recip
  - c22 = a11·recip
  - Negation is 32-bit two's complement, so −0x80000000 wraps to itself.
- start is ignored while busy; the input latches are not disturbed.
- start held high across a done edge is re-accepted on the next cycle, once back in IDLE.

## Timing
- Reset values: state IDLE; c11..c22 = 0; busy, done, singular = 0; internal registers cleared.
- Reset has priority over all other activity. Asserting it mid-operation aborts the computation with no done pulse; outputs return to the reset values on the next edge.
- Edge 0 is the edge where start is sampled in IDLE; busy is high from edge 0.
- Nonsingular path:
  - det registered at edge 1.
  - Divider iterates at edges 2..34.
  - SCALE writes outputs and done at edge 35.
  - Latency is 35 cycles start-to-done; throughput is one inverse per 36 cycles.
- Singular path: outputs, singular=1 and done are written at edge 2.
- done is high for exactly one cycle. busy falls on the same edge that raises done.
- Outputs change only on done edges or reset.

## Test plan
- Identity: a11=a22=0x00010000, a12=a21=0 → done at edge 35, c11=c22=0x00010000, c12=c21=0, singular=0, busy high for edges 0..34.
- Diagonal: a11=0x00020000, a22=0x00040000 → c11=0x00008000, c22=0x00004000, c12=c21=0.
- Negative det, A=[[1,2],[3,4]] → c11=0xFFFE0000, c12=0x00010000, c21=0x00018000, c22=0xFFFF8000.
- Singular, A=[[1,2],[2,4]] → done at edge 2, singular=1, all c*=0.
- Underflow det: a11=a22=0x00000001 → singular=1. Saturation: a11=a22=0x00000100 → q saturates, c11=c22=0x007FFFFF, singular=0.
- Control, in two separate runs:
  - Run 1: pulse start with new A at edge 10 of a busy run → ignored; result matches the original A.
  - Run 2: assert rst at edge 20 → next edge gives busy=0 and c*=0, and done never pulses.
